alu4: RTL and testbench

Registered 4-bit signed arithmetic unit with status flags. It performs add, subtract, multiply or divide on two two's-complement operands, selected per cycle. Result and flags are captured into output registers, giving one cycle of latency. It is a leaf datapath block, driven directly by control logic with no handshake.

---
 rtl/alu4_pkg.sv | 22 ++
 rtl/alu4_div.sv | 38 +++
 rtl/alu4.sv | 116 +++++++++++
 tb/tb_alu4.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu4_pkg.sv
// Shared types and constants for the alu4 registered arithmetic unit.
// Divide support is controlled by the ALU4_DIV_EN macro in alu4.sv.
package alu4_pkg;

    localparam int unsigned ALU4_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic sign;
        logic parity;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/alu4_div.sv
// Combinational signed divider, quotient truncated toward zero.
// Divide-by-zero yields 0; most-negative / -1 yields most-negative with overflow.
module alu4_div
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = ALU4_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow
);

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_mag;
    logic             neg;
    logic [WIDTH-1:0] min_val;

    assign min_val = {1'b1, {(WIDTH-1){1'b0}}};

    // Magnitudes are unsigned, so |most-negative| is representable here.
    assign a_mag = a[WIDTH-1] ? ('0 - a) : a;
    assign b_mag = b[WIDTH-1] ? ('0 - b) : b;
    assign neg   = a[WIDTH-1] ^ b[WIDTH-1];

    always_comb begin
        q_mag    = '0;
        quotient = '0;
        overflow = 1'b0;
        if (b != '0) begin
            q_mag    = a_mag / b_mag;
            quotient = neg ? ('0 - q_mag) : q_mag;
            overflow = (a == min_val) && (b == '1);
        end
    end

endmodule

// File: rtl/alu4.sv
// Registered signed add/sub/mul/div unit with status flags, one cycle latency.
// Define ALU4_DIV_EN to build the divider; otherwise opcode 11 registers zero.
module alu4
    import alu4_pkg::*;
#(
    parameter int unsigned WIDTH = ALU4_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       select,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             parity,
    output logic             overflow
);

    op_e                     op;
    logic [WIDTH:0]          sum_ext;
    logic [WIDTH:0]          diff_ext;
    logic [2*WIDTH-1:0]      a_sx;
    logic [2*WIDTH-1:0]      b_sx;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH:0]          prod_hi;
    logic                    add_ovf;
    logic                    sub_ovf;
    logic                    mul_ovf;
    logic [WIDTH-1:0]        res;
    flags_t                  nxt;

    assign op = op_e'(select);

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);

    // Operands are sign-extended first so the low 2*WIDTH bits are the signed product.
    assign a_sx    = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx    = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod    = a_sx * b_sx;
    assign prod_hi = prod[2*WIDTH-1:WIDTH-1];
    assign mul_ovf = !((prod_hi == '0) || (prod_hi == '1));

`ifdef ALU4_DIV_EN
    logic [WIDTH-1:0] div_q;
    logic             div_ovf;

    alu4_div #(
        .WIDTH(WIDTH)
    ) u_div (
        .a        (a),
        .b        (b),
        .quotient (div_q),
        .overflow (div_ovf)
    );
`endif

    always_comb begin
        res          = '0;
        nxt          = '0;
        case (op)
            OP_ADD: begin
                res          = sum_ext[WIDTH-1:0];
                nxt.carry    = sum_ext[WIDTH];
                nxt.overflow = add_ovf;
            end
            OP_SUB: begin
                res          = diff_ext[WIDTH-1:0];
                nxt.carry    = diff_ext[WIDTH];
                nxt.overflow = sub_ovf;
            end
            OP_MUL: begin
                res          = prod[WIDTH-1:0];
                nxt.overflow = mul_ovf;
            end
            OP_DIV: begin
`ifdef ALU4_DIV_EN
                res          = div_q;
                nxt.overflow = div_ovf;
`else
                res          = '0;
`endif
            end
            default: begin
                res = '0;
            end
        endcase
        nxt.zero   = (res == '0);
        nxt.sign   = res[WIDTH-1];
        nxt.parity = ^res;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            zero     <= 1'b1;
            carry    <= 1'b0;
            sign     <= 1'b0;
            parity   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            out      <= res;
            zero     <= nxt.zero;
            carry    <= nxt.carry;
            sign     <= nxt.sign;
            parity   <= nxt.parity;
            overflow <= nxt.overflow;
        end
    end

endmodule

// File: tb/tb_alu4.sv
// Directed and random self-checking bench for alu4; flags compared as {zero,carry,sign,parity,overflow}.
// Expectations for opcode 11 follow ALU4_DIV_EN.
module tb_alu4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [1:0] select = '0;
    logic [3:0] out;
    logic       zero, carry, sign, parity, overflow;

    int tests = 0;
    int fails = 0;

    alu4 #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .select   (select),
        .out      (out),
        .zero     (zero),
        .carry    (carry),
        .sign     (sign),
        .parity   (parity),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] flags_now();
        return {zero, carry, sign, parity, overflow};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] ts);
        a = ta;
        b = tb;
        select = ts;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic [1:0] ts, input logic [3:0] eout, input logic [4:0] eflg);
        step(ta, tb, ts);
        check({tag, " out"}, 32'(out), 32'(eout));
        check({tag, " flags"}, 32'(flags_now()), 32'(eflg));
    endtask

    // Reference model in plain integer arithmetic, range-checked for overflow.
    function automatic logic [8:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic [1:0] ms);
        int sa, sb, ua, ub, t;
        logic [3:0] r;
        logic c, o;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ua = int'(ma);
        ub = int'(mb);
        t = 0;
        c = 1'b0;
        o = 1'b0;
        case (ms)
            2'b00: begin t = sa + sb; c = (ua + ub) > 15; o = (t > 7) || (t < -8); end
            2'b01: begin t = sa - sb; c = ua < ub;        o = (t > 7) || (t < -8); end
            2'b10: begin t = sa * sb;                     o = (t > 7) || (t < -8); end
            default: begin
`ifdef ALU4_DIV_EN
                if (sb != 0) begin
                    t = sa / sb;
                    o = t > 7;
                end
`endif
            end
        endcase
        r = t[3:0];
        return {r, (r == 4'd0), c, r[3], ^r, o};
    endfunction

    initial begin
        logic [8:0] e;
        logic [3:0] ra, rb;
        logic [1:0] rs;

        // Held in reset with random inputs and a running clock.
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            select = 2'($urandom);
            @(posedge clk);
            #1;
            check("reset out", 32'(out), 32'h0);
            check("reset flags", 32'(flags_now()), 32'(5'b10000));
        end

        @(negedge clk);
        rst_n = 1'b1;
        vec("add 2+3", 4'd2, 4'd3, 2'b00, 4'd5, 5'b00000);
        vec("add 7+1", 4'd7, 4'd1, 2'b00, 4'h8, 5'b00111);
        vec("add -1+1", 4'hF, 4'd1, 2'b00, 4'h0, 5'b11000);
        vec("sub 3-5", 4'd3, 4'd5, 2'b01, 4'hE, 5'b01110);
        vec("sub -8-1", 4'h8, 4'd1, 2'b01, 4'h7, 5'b00011);
        vec("mul -3*3", 4'hD, 4'd3, 2'b10, 4'h7, 5'b00011);
        vec("mul -2*3", 4'hE, 4'd3, 2'b10, 4'hA, 5'b00100);
        vec("mul -8*-1", 4'h8, 4'hF, 2'b10, 4'h8, 5'b00111);
`ifdef ALU4_DIV_EN
        vec("div -7/2", 4'h9, 4'd2, 2'b11, 4'hD, 5'b00110);
        vec("div 7/-2", 4'h7, 4'hE, 2'b11, 4'hD, 5'b00110);
        vec("div -8/-1", 4'h8, 4'hF, 2'b11, 4'h8, 5'b00111);
        vec("div 5/0", 4'd5, 4'd0, 2'b11, 4'h0, 5'b10000);
`else
        vec("div -7/2 off", 4'h9, 4'd2, 2'b11, 4'h0, 5'b10000);
        vec("div -8/-1 off", 4'h8, 4'hF, 2'b11, 4'h0, 5'b10000);
        vec("div 5/0 off", 4'd5, 4'd0, 2'b11, 4'h0, 5'b10000);
`endif

        // Asynchronous reset mid-stream, away from any clock edge.
        vec("pre-reset 7+1", 4'd7, 4'd1, 2'b00, 4'h8, 5'b00111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out", 32'(out), 32'h0);
        check("async reset flags", 32'(flags_now()), 32'(5'b10000));
        @(negedge clk);
        rst_n = 1'b1;
        vec("post-reset 2+3", 4'd2, 4'd3, 2'b00, 4'd5, 5'b00000);

        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            rs = 2'($urandom);
            e = model(ra, rb, rs);
            step(ra, rb, rs);
            check("rand out", 32'(out), 32'(e[8:5]));
            check("rand flags", 32'(flags_now()), 32'(e[4:0]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
